// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the RAM port A arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;
  typedef enum logic [1:0] {NONE, CPU, HOST} rd_tag_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
// clk, rst (async, active-high) | inc: count up | clr: zero (wins over inc)
// cnt: current count | at_max: cnt == MAX
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);
  assign at_max = cnt == W'(MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + W'(1);
endmodule

// File: rtl/ram_port_a_arbiter.sv
// ram_port_a_arbiter: shares data-RAM port A between the CPU memory stage and a host loader
// cpu_*  : CPU request/stall/read-return | host_* : host request/grant/read-return
// ram_*  : RAM port A (address, data, wren out; q in, 1-cycle read latency)
// reset  : asynchronous, active-high
module ram_port_a_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  // The burst grant that enters OWN_HOST counts toward MAX_LOCK, so the
  // owned state exits when lock_cnt hits MAX_LOCK-2 (MAX_LOCK grants total).
  localparam int LOCK_LAST = MAX_LOCK > 1 ? MAX_LOCK - 2 : 0;
  owner_t state, state_nx;
  rd_tag_t rd_tag, rd_tag_nx;
  logic [3:0] wait_cnt;
  logic [7:0] lock_cnt;
  logic wait_max, lock_last, cpu_gnt, wait_inc, lock_clr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, cpu_rdata_q, host_rdata_q;
  sat_counter #(.W(4), .MAX(MAX_WAIT)) u_wait (
    .clk(clk), .rst(reset), .inc(wait_inc), .clr(!wait_inc), .cnt(wait_cnt), .at_max(wait_max)
  );
  sat_counter #(.W(8), .MAX(LOCK_LAST)) u_lock (
    .clk(clk), .rst(reset), .inc(state == OWN_HOST), .clr(lock_clr), .cnt(lock_cnt), .at_max(lock_last)
  );
  always_comb begin
    cpu_gnt   = state == OWN_CPU && cpu_req && !wait_max;
    host_gnt  = host_req && (state == OWN_HOST || !cpu_gnt);
    wait_inc  = host_req && !host_gnt;
    state_nx  = state == OWN_CPU
              ? (host_gnt && host_lock && MAX_LOCK > 1 ? OWN_HOST : OWN_CPU)
              : (host_req && host_lock && !lock_last ? OWN_HOST : OWN_CPU);
    lock_clr  = state == OWN_HOST && state_nx == OWN_CPU;
    cpu_stall = cpu_req && !cpu_gnt;
    ram_address = cpu_gnt ? cpu_addr : host_gnt ? host_addr : addr_q;
    ram_data    = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : data_q;
    ram_wren    = (cpu_gnt && cpu_we) || (host_gnt && host_we);
    rd_tag_nx   = cpu_gnt && !cpu_we ? CPU : host_gnt && !host_we ? HOST : NONE;
    cpu_rvalid  = rd_tag == CPU;
    host_rvalid = rd_tag == HOST;
    cpu_rdata   = cpu_rvalid ? ram_q : cpu_rdata_q;
    host_rdata  = host_rvalid ? ram_q : host_rdata_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= OWN_CPU;
      rd_tag       <= NONE;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state        <= state_nx;
      rd_tag       <= rd_tag_nx;
      addr_q       <= ram_address;
      data_q       <= ram_data;
      cpu_rdata_q  <= cpu_rdata;
      host_rdata_q <= host_rdata;
    end
endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// tb_ram_port_a_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_ram_port_a_arbiter;
  localparam int MW = 4;
  localparam int ML = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [15:0] cpu_addr = 0, host_addr = 0;
  logic [7:0] cpu_wdata = 0, host_wdata = 0;
  logic cpu_stall, cpu_rvalid, host_gnt, host_rvalid, ram_wren;
  logic [7:0] cpu_rdata, host_rdata, ram_data, ram_q;
  logic [15:0] ram_address;
  int n_chk = 0, n_fail = 0;
  ram_port_a_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a == 16'h0010 ? 8'h5A : a == 16'h0030 ? 8'h11 : a == 16'h0040 ? 8'h22 : 8'(a * 3 + 1);
  endfunction
  logic [7:0] ram [0:65535];
  bit written [0:65535];
  always @(posedge clk) begin
    if (ram_wren) begin
      ram[ram_address] <= ram_data;
      written[ram_address] <= 1'b1;
    end
    ram_q <= written[ram_address] ? ram[ram_address] : init_val(ram_address);
  end
  logic [7:0] mmem [int];
  int m_wait = 0, m_burst = 0, m_tag = 0;
  logic [15:0] m_addr = 0;
  logic [7:0] m_tdata = 0, m_crd = 0, m_hrd = 0;
  logic seen_hg, seen_cs;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rs, input logic creq, input logic cwe, input logic [15:0] caddr,
                     input logic [7:0] cwd, input logic hreq, input logic hwe, input logic hlk,
                     input logic [15:0] haddr, input logic [7:0] hwd);
    logic eg_c, eg_h, e_wren;
    logic [15:0] e_addr;
    @(negedge clk);
    reset = rs;
    cpu_req = creq && !rs; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    host_req = hreq && !rs; host_we = hwe; host_lock = hlk; host_addr = haddr; host_wdata = hwd;
    if (rs) begin
      m_wait = 0; m_burst = 0; m_tag = 0; m_addr = 0; m_crd = 0; m_hrd = 0;
    end
    #1;
    eg_c = cpu_req && m_burst == 0 && m_wait < MW;
    eg_h = host_req && (m_burst > 0 || !eg_c);
    e_addr = eg_c ? caddr : eg_h ? haddr : m_addr;
    e_wren = (eg_c && cwe) || (eg_h && hwe);
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_c));
    chk("host_gnt", 32'(host_gnt), 32'(eg_h));
    chk("ram_wren", 32'(ram_wren), 32'(e_wren));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    if (e_wren) chk("ram_data", 32'(ram_data), 32'(eg_c ? cwd : hwd));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_tag == 1));
    chk("host_rvalid", 32'(host_rvalid), 32'(m_tag == 2));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_tag == 1 ? m_tdata : m_crd));
    chk("host_rdata", 32'(host_rdata), 32'(m_tag == 2 ? m_tdata : m_hrd));
    chk("both_rvalid", 32'(cpu_rvalid && host_rvalid), 32'(0));
    seen_hg = host_gnt;
    seen_cs = cpu_stall;
    if (m_tag == 1) m_crd = m_tdata;
    if (m_tag == 2) m_hrd = m_tdata;
    m_tag = eg_c && !cwe ? 1 : eg_h && !hwe ? 2 : 0;
    m_tdata = mmem.exists(int'(e_addr)) ? mmem[int'(e_addr)] : init_val(e_addr);
    if (e_wren) mmem[int'(e_addr)] = eg_c ? cwd : hwd;
    m_wait = host_req && !eg_h ? (m_wait + 1 > MW ? MW : m_wait + 1) : 0;
    m_burst = eg_h && hlk && m_burst + 1 < ML ? m_burst + 1 : 0;
    m_addr = e_addr;
    @(posedge clk);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic got;
    logic g [0:19];
    int nwr, cnt;
    logic hr, hw, hl, rs;
    logic [15:0] ha;
    logic [7:0] hd;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    chk("t1_stall", 32'(seen_cs), 32'(0));
    chk("t1_hgnt", 32'(seen_hg), 32'(0));
    idle();
    chk("t1_rdata", 32'(cpu_rdata), 32'h5A);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 16'h0020, 8'hC3);
    chk("t2_gnt_wr", 32'(seen_hg), 32'(1));
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0020, 0);
    chk("t2_gnt_rd", 32'(seen_hg), 32'(1));
    idle();
    chk("t2_rdata", 32'(host_rdata), 32'hC3);
    idle();
    got = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 16'h0010, 0, !got, 0, 0, 16'h0020, 0);
      chk("t3_hgnt", 32'(seen_hg), 32'(i == 4));
      chk("t3_stall", 32'(seen_cs), 32'(i == 4));
      if (seen_hg) got = 1;
    end
    idle();
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 16'h0011, 0, nwr < 10, 1, 1, 16'(16'h0050 + nwr), 8'(8'hB0 + nwr));
      g[i] = seen_hg;
      if (seen_hg) nwr++;
    end
    cnt = 0;
    for (int i = 4; i < 12; i++) cnt += int'(g[i]);
    chk("t4_burst_len", 32'(cnt), 32'(8));
    chk("t4_pre_burst", 32'(g[3]), 32'(0));
    chk("t4_cpu_slot", 32'(g[12]), 32'(0));
    chk("t4_resume", 32'(g[16]), 32'(1));
    idle();
    for (int i = 0; i < 8; i++)
      cyc(0, i % 2 == 0, 0, 16'h0030, 0, i % 2 == 1, 0, 0, 16'h0040, 0);
    idle();
    cyc(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rvalid_rst", 32'(cpu_rvalid), 32'(0));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t6_rvalid_post", 32'(cpu_rvalid), 32'(0));
    cyc(0, 1, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0);
    chk("t6_cpu_first", 32'(seen_cs), 32'(0));
    hr = 0; hw = 0; hl = 0; ha = 0; hd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hr || seen_hg || $urandom_range(0, 15) == 0) begin
        hr = $urandom_range(0, 3) != 0;
        hw = 1'($urandom);
        hl = $urandom_range(0, 2) != 0;
        ha = 16'(16'h0040 + $urandom_range(0, 15));
        hd = 8'($urandom);
      end
      rs = $urandom_range(0, 99) == 0;
      cyc(rs, $urandom_range(0, 3) != 0, 1'($urandom), 16'(16'h0040 + $urandom_range(0, 15)),
          8'($urandom), hr, hw, hl, ha, hd);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
